// File: rtl/gpr_wb_arb.sv
// Writeback arbiter: two requesters share the register file write port using round-robin grant and a one-cycle output stage.
// Optional macro GPR_WB_FWD_EN compiles in read-data forwarding from the staged write.
module gpr_wb_arb (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Hold,
  input  logic        Req0Valid,
  input  logic [4:0]  Req0RD,
  input  logic [31:0] Req0Data,
  output logic        Req0Ready,
  input  logic        Req1Valid,
  input  logic [4:0]  Req1RD,
  input  logic [31:0] Req1Data,
  output logic        Req1Ready,
  output logic [4:0]  RD,
  output logic        RegWrite,
  output logic [31:0] WData,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  input  logic [31:0] GprRData1,
  input  logic [31:0] GprRData2,
  output logic [31:0] RData1,
  output logic [31:0] RData2
);

  // Handshake: a request transfers on a rising edge where Valid and Ready are both 1;
  // requesters keep Valid/RD/Data stable until that edge, and Ready never depends on RD/Data.
  logic        last_gnt_q, last_gnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt0, gnt1;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Hold) begin
      if (Req0Valid && Req1Valid) begin
        gnt0 = last_gnt_q;
        gnt1 = !last_gnt_q;
      end else begin
        gnt0 = Req0Valid;
        gnt1 = Req1Valid;
      end
    end
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;

  // An accepted r0 write completes the handshake but leaves the write enable low.
  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    if (gnt0) begin
      last_gnt_d = 1'b0;
      rd_d       = Req0RD;
      wdata_d    = Req0Data;
      we_d       = (Req0RD != 5'd0);
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
      rd_d       = Req1RD;
      wdata_d    = Req1Data;
      we_d       = (Req1RD != 5'd0);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_gnt_q <= 1'b1;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RD       = rd_q;
  assign RegWrite = we_q;
  assign WData    = wdata_q;

`ifdef GPR_WB_FWD_EN
  // Covers the cycle before the register file has captured the staged write.
  assign RData1 = (we_q && (rd_q == RS1) && (rd_q != 5'd0)) ? wdata_q : GprRData1;
  assign RData2 = (we_q && (rd_q == RS2) && (rd_q != 5'd0)) ? wdata_q : GprRData2;
`else
  logic unused_rs;
  assign unused_rs = ^{RS1, RS2};
  assign RData1    = GprRData1;
  assign RData2    = GprRData2;
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Bench for gpr_wb_arb: directed vectors, expected writes queued by the driver and checked by a negedge monitor.
module tb_gpr_wb_arb;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Hold;
  logic        Req0Valid, Req1Valid;
  logic [4:0]  Req0RD, Req1RD;
  logic [31:0] Req0Data, Req1Data;
  logic        Req0Ready, Req1Ready;
  logic [4:0]  RD;
  logic        RegWrite;
  logic [31:0] WData;
  logic [4:0]  RS1, RS2;
  logic [31:0] GprRData1, GprRData2;
  logic [31:0] RData1, RData2;

  gpr_wb_arb dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .Req0Valid(Req0Valid), .Req0RD(Req0RD), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1RD(Req1RD), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .RD(RD), .RegWrite(RegWrite), .WData(WData),
    .RS1(RS1), .RS2(RS2), .GprRData1(GprRData1), .GprRData2(GprRData2),
    .RData1(RData1), .RData2(RData2)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Register file model capturing the staged write one edge later
  always @(posedge Clk) begin
    if (RegWrite) rf[RD] <= WData;
  end

  // Scoreboard monitor
  always @(negedge Clk) begin
    logic [36:0] e;
    if (!Reset && RegWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual_rd=%0d actual_data=%h required=no_write", RD, WData);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", {27'd0, RD}, {27'd0, e[36:32]});
        check("wb_data", WData, e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic expect_grant(input logic r0, input logic r1);
    check("req0_ready", {31'd0, Req0Ready}, {31'd0, r0});
    check("req1_ready", {31'd0, Req1Ready}, {31'd0, r1});
    if (r0 && Req0RD != 5'd0) exp_q.push_back({Req0RD, Req0Data});
    if (r1 && Req1RD != 5'd0) exp_q.push_back({Req1RD, Req1Data});
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [4:0] rd, input logic [31:0] d);
    Req0Valid = v; Req0RD = rd; Req0Data = d;
  endtask

  task automatic set_req1(input logic v, input logic [4:0] rd, input logic [31:0] d);
    Req1Valid = v; Req1RD = rd; Req1Data = d;
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    Reset = 1'b1; Hold = 1'b0;
    RS1 = 5'd0; RS2 = 5'd0; GprRData1 = 32'd0; GprRData2 = 32'd0;
    set_req0(1'b1, 5'd1, 32'hA000_0001);
    set_req1(1'b1, 5'd3, 32'hB000_0003);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_rd", {27'd0, RD}, 32'd0);
    check("rst_wdata", WData, 32'd0);

    // Both valid: alternation 0,1,0,1 starting with requester 0
    Reset = 1'b0;
    #1;
    expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b1, 5'd2, 32'hA000_0002);
    @(negedge Clk); expect_grant(1'b0, 1'b1);
    next_cycle();
    set_req1(1'b1, 5'd4, 32'hB000_0004);
    @(negedge Clk); expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);
    @(negedge Clk); expect_grant(1'b0, 1'b1);
    next_cycle();
    set_req1(1'b0, 5'd0, 32'd0);

    // Single requester 0 write and register-file capture
    set_req0(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge Clk); expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    check("single_regwrite", {31'd0, RegWrite}, 32'd1);
    next_cycle();
    check("rf_r5", rf[5], 32'hDEAD_BEEF);

    // Requester 1 write to r0: handshake completes, no write
    set_req1(1'b1, 5'd0, 32'h1234_5678);
    @(negedge Clk); expect_grant(1'b0, 1'b1);
    next_cycle();
    set_req1(1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    check("r0_regwrite", {31'd0, RegWrite}, 32'd0);
    next_cycle();
    check("rf_r0", rf[0], 32'd0);

    // Hold rises with a write staged; that write still completes
    set_req0(1'b1, 5'd9, 32'h0000_0009);
    @(negedge Clk); expect_grant(1'b1, 1'b0);
    next_cycle();
    Hold = 1'b1;
    set_req0(1'b1, 5'd11, 32'hA000_000B);
    set_req1(1'b1, 5'd10, 32'hB000_000A);
    @(negedge Clk); expect_grant(1'b0, 1'b0);
    check("hold_staged_write", {31'd0, RegWrite}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge Clk); expect_grant(1'b0, 1'b0);
      check("hold_regwrite", {31'd0, RegWrite}, 32'd0);
    end
    next_cycle();
    Hold = 1'b0;
    @(negedge Clk); expect_grant(1'b0, 1'b1);
    next_cycle();
    set_req1(1'b0, 5'd0, 32'd0);
    @(negedge Clk); expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);

    // Forwarding of the staged write
    RS1 = 5'd7; RS2 = 5'd7; GprRData1 = 32'd0; GprRData2 = 32'h1111_1111;
    set_req0(1'b1, 5'd7, 32'hA5A5_A5A5);
    @(negedge Clk); expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b1, 5'd0, 32'h0000_FFFF);
    @(negedge Clk);
`ifdef GPR_WB_FWD_EN
    check("fwd_rdata1", RData1, 32'hA5A5_A5A5);
    check("fwd_rdata2", RData2, 32'hA5A5_A5A5);
`else
    check("fwd_rdata1", RData1, 32'd0);
    check("fwd_rdata2", RData2, 32'h1111_1111);
`endif
    expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);
    RS1 = 5'd0; GprRData1 = 32'h0000_0055;
    @(negedge Clk);
    check("fwd_r0_rdata1", RData1, 32'h0000_0055);
    check("fwd_r0_rdata2", RData2, 32'h1111_1111);

    // Reset mid-operation discards the staged write at once
    set_req0(1'b1, 5'd12, 32'hC000_000C);
    #1; expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("midrst_rd", {27'd0, RD}, 32'd0);
    next_cycle();
    check("midrst_rf_r12", rf[12], 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // After reset requester 0 wins the tie again
    set_req0(1'b1, 5'd13, 32'hA000_000D);
    set_req1(1'b1, 5'd14, 32'hB000_000E);
    #1; expect_grant(1'b1, 1'b0);
    next_cycle();
    set_req0(1'b0, 5'd0, 32'd0);
    set_req1(1'b0, 5'd0, 32'd0);

    repeat (3) @(negedge Clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
